rtc_clcd_clock_display: RTL and testbench



---
 rtl/rtc_clcd_clock_display.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rtc_clcd_clock_display.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_clcd_clock_display.sv
// Reads the DS1302 time registers and writes "HH:MM:SS" to the character LCD.
// Skips the LCD write when the time has not changed since the last display.
module rtc_clcd_clock_display #(
   parameter int unsigned REFRESH_CYCLES = 25_000_000,
   parameter int unsigned LCD_ROW        = 0,
   parameter int unsigned LCD_COL        = 0,
   parameter int unsigned BUSY_TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       i_enable,
   output logic [7:0] o_rtc_addr,
   output logic [7:0] o_rtc_data,
   output logic       o_rtc_valid,
   input  logic       i_rtc_busy,
   input  logic [7:0] i_rtc_receive,
   output logic [7:0] o_data,
   output logic       o_RS,
   output logic       o_RW,
   output logic       o_valid,
   input  logic       i_busy,
   output logic [7:0] o_sec,
   output logic [7:0] o_min,
   output logic [7:0] o_hour,
   output logic       o_update,
   output logic       o_err
);

   localparam int unsigned TIMER_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int unsigned TMO_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(REFRESH_CYCLES - 1);
   localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(BUSY_TIMEOUT - 1);
   localparam logic [7:0] CMD_BYTE = 8'h80 | ((LCD_ROW != 0) ? 8'h40 : 8'h00) | 8'(LCD_COL);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT_LO, CMP, LCD_REQ, LCD_WAIT_LO, DONE
   } state_t;

   state_t             state, state_nx;
   logic [TIMER_W-1:0] timer, timer_nx;
   logic [TMO_W-1:0]   tmo, tmo_nx;
   logic [1:0]         k, k_nx;
   logic [3:0]         j, j_nx;
   logic [7:0]         cap_sec, cap_min, cap_hour;
   logic [7:0]         cap_sec_nx, cap_min_nx, cap_hour_nx;
   logic [7:0]         shd_sec, shd_min, shd_hour;
   logic [7:0]         shd_sec_nx, shd_min_nx, shd_hour_nx;
   logic [7:0]         sec_nx, min_nx, hour_nx;
   logic [7:0]         rtc_addr_nx, data_nx;
   logic               rtc_valid_nx, valid_nx, rs_nx, update_nx, err_nx;

   assign o_rtc_data = 8'h00;
   assign o_RW       = 1'b0;

   function automatic logic [7:0] digit(input logic [3:0] n);
      return 8'h30 + {4'h0, n};
   endfunction

   // Character for LCD transfer idx (1..8) of "HH:MM:SS".
   function automatic logic [7:0] lcd_char(input logic [3:0] idx, input logic [7:0] h,
                                           input logic [7:0] m, input logic [7:0] s);
      case (idx)
         4'd1:    return digit(h[7:4]);
         4'd2:    return digit(h[3:0]);
         4'd4:    return digit(m[7:4]);
         4'd5:    return digit(m[3:0]);
         4'd7:    return digit(s[7:4]);
         4'd8:    return digit(s[3:0]);
         default: return 8'h3A;
      endcase
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state       <= IDLE;
         timer       <= '0;
         tmo         <= '0;
         k           <= '0;
         j           <= '0;
         cap_sec     <= '0;
         cap_min     <= '0;
         cap_hour    <= '0;
         shd_sec     <= 8'hFF;
         shd_min     <= 8'hFF;
         shd_hour    <= 8'hFF;
         o_sec       <= '0;
         o_min       <= '0;
         o_hour      <= '0;
         o_rtc_addr  <= '0;
         o_rtc_valid <= 1'b0;
         o_data      <= '0;
         o_RS        <= 1'b0;
         o_valid     <= 1'b0;
         o_update    <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         state       <= state_nx;
         timer       <= timer_nx;
         tmo         <= tmo_nx;
         k           <= k_nx;
         j           <= j_nx;
         cap_sec     <= cap_sec_nx;
         cap_min     <= cap_min_nx;
         cap_hour    <= cap_hour_nx;
         shd_sec     <= shd_sec_nx;
         shd_min     <= shd_min_nx;
         shd_hour    <= shd_hour_nx;
         o_sec       <= sec_nx;
         o_min       <= min_nx;
         o_hour      <= hour_nx;
         o_rtc_addr  <= rtc_addr_nx;
         o_rtc_valid <= rtc_valid_nx;
         o_data      <= data_nx;
         o_RS        <= rs_nx;
         o_valid     <= valid_nx;
         o_update    <= update_nx;
         o_err       <= err_nx;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx     = state;
      timer_nx     = timer;
      tmo_nx       = tmo;
      k_nx         = k;
      j_nx         = j;
      cap_sec_nx   = cap_sec;
      cap_min_nx   = cap_min;
      cap_hour_nx  = cap_hour;
      shd_sec_nx   = shd_sec;
      shd_min_nx   = shd_min;
      shd_hour_nx  = shd_hour;
      sec_nx       = o_sec;
      min_nx       = o_min;
      hour_nx      = o_hour;
      rtc_addr_nx  = o_rtc_addr;
      rtc_valid_nx = o_rtc_valid;
      data_nx      = o_data;
      rs_nx        = o_RS;
      valid_nx     = o_valid;
      update_nx    = 1'b0;
      err_nx       = 1'b0;

      case (state)
         IDLE: begin
            if (timer != TIMER_MAX) begin
               timer_nx = timer + 1'b1;
            end else if (i_enable && !i_busy && !i_rtc_busy) begin
               state_nx     = RD_REQ;
               timer_nx     = '0;
               tmo_nx       = '0;
               k_nx         = '0;
               rtc_addr_nx  = 8'h81;
               rtc_valid_nx = 1'b1;
            end
         end

         RD_REQ: begin
            if (i_rtc_busy) begin
               rtc_valid_nx = 1'b0;
               tmo_nx       = '0;
               state_nx     = RD_WAIT_LO;
            end else if (tmo == TMO_MAX) begin
               rtc_valid_nx = 1'b0;
               err_nx       = 1'b1;
               tmo_nx       = '0;
               state_nx     = IDLE;
            end else begin
               tmo_nx = tmo + 1'b1;
            end
         end

         RD_WAIT_LO: begin
            if (!i_rtc_busy) begin
               case (k)
                  2'd0:    cap_sec_nx  = i_rtc_receive & 8'h7F;
                  2'd1:    cap_min_nx  = i_rtc_receive & 8'h7F;
                  default: cap_hour_nx = i_rtc_receive & 8'h3F;
               endcase
               tmo_nx = '0;
               if (k == 2'd2) begin
                  state_nx = CMP;
               end else begin
                  k_nx         = k + 2'd1;
                  rtc_addr_nx  = 8'h81 + 8'({k_nx, 1'b0});
                  rtc_valid_nx = 1'b1;
                  state_nx     = RD_REQ;
               end
            end else if (tmo == TMO_MAX) begin
               err_nx   = 1'b1;
               tmo_nx   = '0;
               state_nx = IDLE;
            end else begin
               tmo_nx = tmo + 1'b1;
            end
         end

         CMP: begin
            if (cap_sec == shd_sec && cap_min == shd_min && cap_hour == shd_hour) begin
               state_nx = IDLE;
            end else begin
               sec_nx   = cap_sec;
               min_nx   = cap_min;
               hour_nx  = cap_hour;
               j_nx     = '0;
               data_nx  = CMD_BYTE;
               rs_nx    = 1'b0;
               valid_nx = 1'b1;
               tmo_nx   = '0;
               state_nx = LCD_REQ;
            end
         end

         LCD_REQ: begin
            if (i_busy) begin
               valid_nx = 1'b0;
               tmo_nx   = '0;
               state_nx = LCD_WAIT_LO;
            end else if (tmo == TMO_MAX) begin
               valid_nx = 1'b0;
               err_nx   = 1'b1;
               tmo_nx   = '0;
               state_nx = IDLE;
            end else begin
               tmo_nx = tmo + 1'b1;
            end
         end

         LCD_WAIT_LO: begin
            if (!i_busy) begin
               tmo_nx = '0;
               if (j == 4'd8) begin
                  state_nx = DONE;
               end else begin
                  j_nx     = j + 4'd1;
                  data_nx  = lcd_char(j_nx, cap_hour, cap_min, cap_sec);
                  rs_nx    = 1'b1;
                  valid_nx = 1'b1;
                  state_nx = LCD_REQ;
               end
            end else if (tmo == TMO_MAX) begin
               err_nx   = 1'b1;
               tmo_nx   = '0;
               state_nx = IDLE;
            end else begin
               tmo_nx = tmo + 1'b1;
            end
         end

         DONE: begin
            shd_sec_nx  = cap_sec;
            shd_min_nx  = cap_min;
            shd_hour_nx = cap_hour;
            update_nx   = 1'b1;
            state_nx    = IDLE;
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rtc_clcd_clock_display.sv
// Directed bench for rtc_clcd_clock_display with DS1302 and CLCD responder models.
module tb_rtc_clcd_clock_display;

   localparam int unsigned REFRESH = 16;
   localparam int unsigned TMO     = 64;

   logic clk, reset_p, en, sel, lcd_stuck;
   logic rtc_busy, lcd_busy;
   logic [7:0] rtc_receive;

   logic [7:0] a_rtc_addr, a_rtc_data, a_data, a_sec, a_min, a_hour;
   logic       a_rtc_valid, a_RS, a_RW, a_valid, a_update, a_err;
   logic [7:0] b_rtc_addr, b_rtc_data, b_data, b_sec, b_min, b_hour;
   logic       b_rtc_valid, b_RS, b_RW, b_valid, b_update, b_err;

   logic [7:0] rtc_sec_v, rtc_min_v, rtc_hour_v, rtc_cur;
   int rtc_cnt, lcd_cnt;
   int upd_cyc, err_cyc, val_cyc, rv_cyc;
   int errors, checks;

   logic [7:0] rtc_exp[$], rtc_obs[$];
   logic [8:0] lcd_exp[$], lcd_obs[$];

   wire       m_rtc_valid = sel ? b_rtc_valid : a_rtc_valid;
   wire [7:0] m_rtc_addr  = sel ? b_rtc_addr  : a_rtc_addr;
   wire       m_valid     = sel ? b_valid     : a_valid;
   wire [7:0] m_data      = sel ? b_data      : a_data;
   wire       m_rs        = sel ? b_RS        : a_RS;

   rtc_clcd_clock_display #(.REFRESH_CYCLES(REFRESH), .LCD_ROW(0), .LCD_COL(0), .BUSY_TIMEOUT(TMO)) dut_a (
      .clk(clk), .reset_p(reset_p), .i_enable(en & ~sel),
      .o_rtc_addr(a_rtc_addr), .o_rtc_data(a_rtc_data), .o_rtc_valid(a_rtc_valid),
      .i_rtc_busy(rtc_busy), .i_rtc_receive(rtc_receive),
      .o_data(a_data), .o_RS(a_RS), .o_RW(a_RW), .o_valid(a_valid), .i_busy(lcd_busy),
      .o_sec(a_sec), .o_min(a_min), .o_hour(a_hour), .o_update(a_update), .o_err(a_err));

   rtc_clcd_clock_display #(.REFRESH_CYCLES(REFRESH), .LCD_ROW(1), .LCD_COL(4), .BUSY_TIMEOUT(TMO)) dut_b (
      .clk(clk), .reset_p(reset_p), .i_enable(en & sel),
      .o_rtc_addr(b_rtc_addr), .o_rtc_data(b_rtc_data), .o_rtc_valid(b_rtc_valid),
      .i_rtc_busy(rtc_busy), .i_rtc_receive(rtc_receive),
      .o_data(b_data), .o_RS(b_RS), .o_RW(b_RW), .o_valid(b_valid), .i_busy(lcd_busy),
      .o_sec(b_sec), .o_min(b_min), .o_hour(b_hour), .o_update(b_update), .o_err(b_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rtc_val(input logic [7:0] a);
      case (a)
         8'h81:   return rtc_sec_v;
         8'h83:   return rtc_min_v;
         8'h85:   return rtc_hour_v;
         default: return 8'hEE;
      endcase
   endfunction

   // DS1302 model: accepts a request, raises busy a few cycles later, returns data as busy falls.
   always @(negedge clk) begin
      if (reset_p) begin
         rtc_cnt  <= 0;
         rtc_busy <= 1'b0;
      end else if (rtc_cnt == 0) begin
         if (m_rtc_valid) begin
            rtc_obs.push_back(m_rtc_addr);
            rtc_cur <= m_rtc_addr;
            rtc_cnt <= 1;
         end
      end else if (rtc_cnt == 6) begin
         rtc_receive <= rtc_val(rtc_cur);
         rtc_busy    <= 1'b0;
         rtc_cnt     <= 0;
      end else begin
         if (rtc_cnt == 2) rtc_busy <= 1'b1;
         rtc_cnt <= rtc_cnt + 1;
      end
   end

   // CLCD generator model: records {RS,data}; optionally never goes busy.
   always @(negedge clk) begin
      if (reset_p) begin
         lcd_cnt  <= 0;
         lcd_busy <= 1'b0;
      end else if (lcd_cnt == 0) begin
         if (m_valid && !lcd_stuck) begin
            lcd_obs.push_back({m_rs, m_data});
            lcd_cnt <= 1;
         end
      end else if (lcd_cnt == 5) begin
         lcd_busy <= 1'b0;
         lcd_cnt  <= 0;
      end else begin
         if (lcd_cnt == 2) lcd_busy <= 1'b1;
         lcd_cnt <= lcd_cnt + 1;
      end
   end

   // Cycle counters for pulse widths and quiet periods.
   always @(negedge clk) begin
      if (a_update | b_update) upd_cyc <= upd_cyc + 1;
      if (a_err | b_err)       err_cyc <= err_cyc + 1;
      if (m_valid)             val_cyc <= val_cyc + 1;
      if (m_rtc_valid)         rv_cyc  <= rv_cyc + 1;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_rtc();
      rtc_exp.push_back(8'h81);
      rtc_exp.push_back(8'h83);
      rtc_exp.push_back(8'h85);
   endtask

   task automatic push_lcd(input logic [7:0] cmd, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s);
      lcd_exp.push_back({1'b0, cmd});
      lcd_exp.push_back({1'b1, 8'h30 + 8'(h[7:4])});
      lcd_exp.push_back({1'b1, 8'h30 + 8'(h[3:0])});
      lcd_exp.push_back(9'h13A);
      lcd_exp.push_back({1'b1, 8'h30 + 8'(m[7:4])});
      lcd_exp.push_back({1'b1, 8'h30 + 8'(m[3:0])});
      lcd_exp.push_back(9'h13A);
      lcd_exp.push_back({1'b1, 8'h30 + 8'(s[7:4])});
      lcd_exp.push_back({1'b1, 8'h30 + 8'(s[3:0])});
   endtask

   task automatic cmp_rtc(input string tag);
      chk({tag, "_rtc_count"}, 32'(rtc_obs.size()), 32'(rtc_exp.size()));
      while (rtc_obs.size() > 0 && rtc_exp.size() > 0)
         chk({tag, "_rtc_addr"}, 32'(rtc_obs.pop_front()), 32'(rtc_exp.pop_front()));
      rtc_obs.delete();
      rtc_exp.delete();
   endtask

   task automatic cmp_lcd(input string tag);
      chk({tag, "_lcd_count"}, 32'(lcd_obs.size()), 32'(lcd_exp.size()));
      while (lcd_obs.size() > 0 && lcd_exp.size() > 0)
         chk({tag, "_lcd_byte"}, 32'(lcd_obs.pop_front()), 32'(lcd_exp.pop_front()));
      lcd_obs.delete();
      lcd_exp.delete();
   endtask

   task automatic run_to_update(input string tag, input int target);
      en = 1'b1;
      for (int i = 0; i < 2000 && upd_cyc < target; i++) tick();
      en = 1'b0;
      chk({tag, "_update_seen"}, 32'(upd_cyc >= target), 32'd1);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, v0, r0;
      errors = 0; checks = 0;
      upd_cyc = 0; err_cyc = 0; val_cyc = 0; rv_cyc = 0;
      reset_p = 1'b1; en = 1'b0; sel = 1'b0; lcd_stuck = 1'b0;
      rtc_receive = 8'h00; rtc_cur = 8'h00;
      rtc_sec_v = 8'h80; rtc_min_v = 8'h59; rtc_hour_v = 8'h23;
      repeat (3) tick();

      // Reset state
      chk("rst_rtc_valid", 32'(a_rtc_valid), 32'd0);
      chk("rst_valid", 32'(a_valid), 32'd0);
      chk("rst_time", {8'h00, a_hour, a_min, a_sec}, 32'd0);
      chk("rst_pulses", {30'd0, a_update, a_err}, 32'd0);
      chk("rst_data", {16'd0, a_rtc_addr, a_data}, 32'd0);
      reset_p = 1'b0;
      tick();

      // First refresh: CH bit masked, full 9-byte write
      push_rtc();
      lcd_exp = '{9'h080, 9'h132, 9'h133, 9'h13A, 9'h135, 9'h139, 9'h13A, 9'h130, 9'h130};
      run_to_update("first", 1);
      chk("first_sec", 32'(a_sec), 32'h00);
      chk("first_min", 32'(a_min), 32'h59);
      chk("first_hour", 32'(a_hour), 32'h23);
      chk("first_const", {a_rtc_data, 7'd0, a_RW}, 32'd0);
      cmp_rtc("first");
      cmp_lcd("first");
      repeat (3) tick();
      chk("first_update_width", 32'(upd_cyc), 32'd1);

      // Same time again: reads happen, no LCD traffic, no update
      push_rtc();
      en = 1'b1;
      for (int i = 0; i < 1000 && rtc_obs.size() < 3; i++) tick();
      en = 1'b0;
      repeat (40) tick();
      cmp_rtc("same");
      chk("same_no_lcd", 32'(lcd_obs.size()), 32'd0);
      chk("same_no_update", 32'(upd_cyc), 32'd1);

      // Disabled: no RTC requests for 10 refresh periods
      r0 = rv_cyc;
      repeat (10 * REFRESH) tick();
      chk("disabled_quiet", 32'(rv_cyc - r0), 32'd0);

      // Enable with a changed second and an LCD that never goes busy
      rtc_sec_v = 8'h05;
      lcd_stuck = 1'b1;
      push_rtc();
      v0 = val_cyc;
      en = 1'b1;
      n = 0;
      while (!a_rtc_valid && n < 40) begin tick(); n++; end
      en = 1'b0;
      chk("start_latency", 32'(n <= int'(REFRESH) + 1), 32'd1);
      for (int i = 0; i < 2000 && err_cyc < 1; i++) tick();
      chk("tmo_err_seen", 32'(err_cyc), 32'd1);
      chk("tmo_valid_cycles", 32'(val_cyc - v0), 32'(TMO));
      chk("tmo_valid_low", 32'(a_valid), 32'd0);
      chk("tmo_sec_updated", 32'(a_sec), 32'h05);
      repeat (3) tick();
      chk("tmo_err_width", 32'(err_cyc), 32'd1);
      chk("tmo_no_update", 32'(upd_cyc), 32'd1);
      cmp_rtc("tmo");

      // Retry after abort rewrites everything (shadows untouched by the abort)
      lcd_stuck = 1'b0;
      push_rtc();
      push_lcd(8'h80, 8'h23, 8'h59, 8'h05);
      run_to_update("retry", 2);
      cmp_rtc("retry");
      cmp_lcd("retry");

      // Row 1, column 4 instance: seconds 00 then 01
      sel = 1'b1;
      rtc_sec_v = 8'h00;
      push_rtc();
      push_lcd(8'hC4, 8'h23, 8'h59, 8'h00);
      run_to_update("rowcol0", 3);
      cmp_rtc("rowcol0");
      cmp_lcd("rowcol0");
      rtc_sec_v = 8'h01;
      push_rtc();
      push_lcd(8'hC4, 8'h23, 8'h59, 8'h01);
      run_to_update("rowcol1", 4);
      chk("rowcol1_sec", 32'(b_sec), 32'h01);
      cmp_rtc("rowcol1");
      cmp_lcd("rowcol1");
      sel = 1'b0;

      // Reset during the 5th LCD transfer
      rtc_sec_v = 8'h30; rtc_min_v = 8'h12; rtc_hour_v = 8'h07;
      push_rtc();
      push_lcd(8'h80, 8'h07, 8'h12, 8'h30);
      en = 1'b1;
      for (int i = 0; i < 2000 && lcd_obs.size() < 5; i++) tick();
      en = 1'b0;
      chk("mid_valid_before", 32'(a_valid), 32'd1);
      reset_p = 1'b1;
      #1;
      chk("mid_valid_async", 32'(a_valid), 32'd0);
      chk("mid_rtc_valid_async", 32'(a_rtc_valid), 32'd0);
      chk("mid_sec_async", 32'(a_sec), 32'd0);
      while (lcd_exp.size() > 5) void'(lcd_exp.pop_back());
      cmp_rtc("mid");
      cmp_lcd("mid");
      repeat (3) tick();
      reset_p = 1'b0;

      // Values equal to the pre-reset shadows still force a full rewrite
      rtc_sec_v = 8'h05; rtc_min_v = 8'h59; rtc_hour_v = 8'h23;
      push_rtc();
      push_lcd(8'h80, 8'h23, 8'h59, 8'h05);
      run_to_update("post", 5);
      cmp_rtc("post");
      cmp_lcd("post");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
